// File: rtl/e_stage_reg.sv
// Decode-to-execute pipeline register: forwarding, load-use/interlock stall, bubble injection.
// Define E_FWD_EN to build the E/M/W forwarding network; otherwise a full RAW interlock is used.
module e_stage_reg (
    input  logic        clk,
    input  logic        rst,
    input  logic        d_valid,
    input  logic [5:0]  d_op,
    input  logic [5:0]  d_funct,
    input  logic [4:0]  d_srcA,
    input  logic [4:0]  d_srcB,
    input  logic [4:0]  d_dst,
    input  logic [31:0] d_valA,
    input  logic [31:0] d_valB,
    input  logic [31:0] d_valC,
    input  logic [31:0] e_valE,
    input  logic [4:0]  M_dst,
    input  logic        M_isload,
    input  logic [31:0] M_valE,
    input  logic [31:0] m_valM,
    input  logic [4:0]  W_dst,
    input  logic [31:0] W_val,
    input  logic        m_stall,
    output logic [5:0]  E_op,
    output logic [5:0]  E_funct,
    output logic [31:0] E_valA,
    output logic [31:0] E_valB,
    output logic [31:0] E_valC,
    output logic [4:0]  E_dst,
    output logic [4:0]  E_srcA,
    output logic [4:0]  E_srcB,
    output logic        E_bubble,
    output logic        D_stall
);
    localparam logic [5:0] IROP = 6'h00;

    logic [5:0]  op_q, op_d, funct_q, funct_d;
    logic [31:0] valA_q, valA_d, valB_q, valB_d, valC_q, valC_d;
    logic [4:0]  dst_q, dst_d, srcA_q, srcA_d, srcB_q, srcB_d;
    logic        bubble_q, bubble_d;
    logic        hazard;
    logic [31:0] opA, opB;

`ifdef E_FWD_EN
    localparam logic [5:0] ILW = 6'h23;

    logic        e_fwd_ok;
    logic [31:0] m_val;

    // A load in E has no result yet; its consumer is stalled by the hazard logic instead.
    assign e_fwd_ok = (op_q != ILW) && !bubble_q;
    assign m_val    = M_isload ? m_valM : M_valE;

    function automatic logic [31:0] fwd_sel(
        input logic [4:0]  idx,
        input logic [31:0] rf,
        input logic [4:0]  e_dst,
        input logic        e_ok,
        input logic [31:0] e_val,
        input logic [4:0]  m_dst,
        input logic [31:0] m_v,
        input logic [4:0]  w_dst,
        input logic [31:0] w_v
    );
        logic [31:0] r;
        if (idx == '0)                     r = '0;
        else if (idx == e_dst && e_ok)     r = e_val;
        else if (idx == m_dst)             r = m_v;
        else if (idx == w_dst)             r = w_v;
        else                               r = rf;
        return r;
    endfunction

    assign opA = fwd_sel(d_srcA, d_valA, dst_q, e_fwd_ok, e_valE, M_dst, m_val, W_dst, W_val);
    assign opB = fwd_sel(d_srcB, d_valB, dst_q, e_fwd_ok, e_valE, M_dst, m_val, W_dst, W_val);

    assign hazard = (op_q == ILW) && (dst_q != '0) && d_valid &&
                    ((dst_q == d_srcA) || (dst_q == d_srcB));
`else
    logic hitA, hitB;
    logic unused_fwd;

    assign hitA = (d_srcA != '0) &&
                  (((d_srcA == dst_q) && !bubble_q) || (d_srcA == M_dst) || (d_srcA == W_dst));
    assign hitB = (d_srcB != '0) &&
                  (((d_srcB == dst_q) && !bubble_q) || (d_srcB == M_dst) || (d_srcB == W_dst));

    assign hazard     = d_valid && (hitA || hitB);
    assign opA        = d_valA;
    assign opB        = d_valB;
    assign unused_fwd = ^{e_valE, M_isload, M_valE, m_valM, W_val};
`endif

    // A memory stall outranks the hazard: E holds rather than taking a bubble.
    assign D_stall = m_stall || hazard;

    always_comb begin
        op_d     = op_q;
        funct_d  = funct_q;
        valA_d   = valA_q;
        valB_d   = valB_q;
        valC_d   = valC_q;
        dst_d    = dst_q;
        srcA_d   = srcA_q;
        srcB_d   = srcB_q;
        bubble_d = bubble_q;
        if (!m_stall) begin
            if (hazard || !d_valid) begin
                op_d     = IROP;
                funct_d  = '0;
                valA_d   = '0;
                valB_d   = '0;
                valC_d   = '0;
                dst_d    = '0;
                srcA_d   = '0;
                srcB_d   = '0;
                bubble_d = 1'b1;
            end else begin
                op_d     = d_op;
                funct_d  = d_funct;
                valA_d   = opA;
                valB_d   = opB;
                valC_d   = d_valC;
                dst_d    = d_dst;
                srcA_d   = d_srcA;
                srcB_d   = d_srcB;
                bubble_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q     <= IROP;
            funct_q  <= '0;
            valA_q   <= '0;
            valB_q   <= '0;
            valC_q   <= '0;
            dst_q    <= '0;
            srcA_q   <= '0;
            srcB_q   <= '0;
            bubble_q <= 1'b1;
        end else begin
            op_q     <= op_d;
            funct_q  <= funct_d;
            valA_q   <= valA_d;
            valB_q   <= valB_d;
            valC_q   <= valC_d;
            dst_q    <= dst_d;
            srcA_q   <= srcA_d;
            srcB_q   <= srcB_d;
            bubble_q <= bubble_d;
        end
    end

    assign E_op     = op_q;
    assign E_funct  = funct_q;
    assign E_valA   = valA_q;
    assign E_valB   = valB_q;
    assign E_valC   = valC_q;
    assign E_dst    = dst_q;
    assign E_srcA   = srcA_q;
    assign E_srcB   = srcB_q;
    assign E_bubble = bubble_q;
endmodule

// File: tb/tb_e_stage_reg.sv
// Directed self-checking bench for e_stage_reg; covers both E_FWD_EN builds.
module tb_e_stage_reg;
    localparam logic [5:0] ILW  = 6'h23;
    localparam logic [5:0] FADD = 6'h20;

    logic        clk = 1'b0;
    logic        rst, d_valid, M_isload, m_stall;
    logic [5:0]  d_op, d_funct;
    logic [4:0]  d_srcA, d_srcB, d_dst, M_dst, W_dst;
    logic [31:0] d_valA, d_valB, d_valC, e_valE, M_valE, m_valM, W_val;
    logic [5:0]  E_op, E_funct;
    logic [31:0] E_valA, E_valB, E_valC;
    logic [4:0]  E_dst, E_srcA, E_srcB;
    logic        E_bubble, D_stall;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    e_stage_reg dut (
        .clk(clk), .rst(rst), .d_valid(d_valid), .d_op(d_op), .d_funct(d_funct),
        .d_srcA(d_srcA), .d_srcB(d_srcB), .d_dst(d_dst),
        .d_valA(d_valA), .d_valB(d_valB), .d_valC(d_valC), .e_valE(e_valE),
        .M_dst(M_dst), .M_isload(M_isload), .M_valE(M_valE), .m_valM(m_valM),
        .W_dst(W_dst), .W_val(W_val), .m_stall(m_stall),
        .E_op(E_op), .E_funct(E_funct), .E_valA(E_valA), .E_valB(E_valB), .E_valC(E_valC),
        .E_dst(E_dst), .E_srcA(E_srcA), .E_srcB(E_srcB), .E_bubble(E_bubble), .D_stall(D_stall)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_e(input string tag, input logic [5:0] op, input logic [5:0] fn,
                         input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc,
                         input logic [4:0] ds, input logic [4:0] sa, input logic [4:0] sb,
                         input logic bub);
        chk({tag, ".op"},     {26'd0, E_op},    {26'd0, op});
        chk({tag, ".funct"},  {26'd0, E_funct}, {26'd0, fn});
        chk({tag, ".valA"},   E_valA, va);
        chk({tag, ".valB"},   E_valB, vb);
        chk({tag, ".valC"},   E_valC, vc);
        chk({tag, ".dst"},    {27'd0, E_dst},  {27'd0, ds});
        chk({tag, ".srcA"},   {27'd0, E_srcA}, {27'd0, sa});
        chk({tag, ".srcB"},   {27'd0, E_srcB}, {27'd0, sb});
        chk({tag, ".bubble"}, {31'd0, E_bubble}, {31'd0, bub});
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic set_d(input logic v, input logic [5:0] op, input logic [5:0] fn,
                         input logic [4:0] sa, input logic [4:0] sb, input logic [4:0] ds,
                         input logic [31:0] va, input logic [31:0] vb, input logic [31:0] vc);
        d_valid = v;  d_op = op;   d_funct = fn;
        d_srcA  = sa; d_srcB = sb; d_dst = ds;
        d_valA  = va; d_valB = vb; d_valC = vc;
    endtask

    initial begin
        rst = 1'b1; m_stall = 1'b0; M_isload = 1'b0;
        M_dst = '0; W_dst = '0; e_valE = '0; M_valE = '0; m_valM = '0; W_val = '0;
        set_d(1'b0, '0, '0, '0, '0, '0, '0, '0, '0);

        // reset, then a plain load, then reset asserted during a memory stall
        tick; tick;
        chk_e("rst", 6'h00, 6'h00, 0, 0, 0, 0, 0, 0, 1'b1);
        chk("rst.D_stall", {31'd0, D_stall}, 32'd0);
        rst = 1'b0;
        set_d(1'b1, 6'h00, FADD, 5'd1, 5'd2, 5'd3, 32'h1111_0001, 32'h2222_0002, 32'h0000_0033);
        #1 chk("load.D_stall", {31'd0, D_stall}, 32'd0);
        tick;
        chk_e("load", 6'h00, FADD, 32'h1111_0001, 32'h2222_0002, 32'h0000_0033, 5'd3, 5'd1, 5'd2, 1'b0);
        rst = 1'b1; m_stall = 1'b1;
        tick;
        chk_e("rst_over_stall", 6'h00, 6'h00, 0, 0, 0, 0, 0, 0, 1'b1);
        rst = 1'b0; m_stall = 1'b0;

        // d_valid=0 injects a bubble
        tick;
        set_d(1'b0, 6'h00, FADD, 5'd1, 5'd2, 5'd3, 32'h5, 32'h6, 32'h7);
        tick;
        chk("invalid.bubble", {31'd0, E_bubble}, 32'd1);
        chk("invalid.dst", {27'd0, E_dst}, 32'd0);

        // lw $8, 4($29)
        set_d(1'b1, ILW, 6'h00, 5'd29, 5'd0, 5'd8, 32'd100, 32'd0, 32'd4);
        tick;
        chk("lw.op", {26'd0, E_op}, {26'd0, ILW});
        chk("lw.valA", E_valA, 32'd100);

        // dependent add under a 3-cycle memory stall: E must hold, no bubble
        set_d(1'b1, 6'h00, FADD, 5'd8, 5'd0, 5'd9, 32'h55, 32'h0, 32'h0);
        m_stall = 1'b1;
        for (int unsigned i = 0; i < 3; i++) begin
            e_valE = 32'hBAD0_0000 + i; M_dst = 5'd8; M_valE = 32'hBAD1_0000; W_dst = 5'd8;
            #1 chk("mstall.D_stall", {31'd0, D_stall}, 32'd1);
            tick;
            chk("mstall.op", {26'd0, E_op}, {26'd0, ILW});
            chk("mstall.dst", {27'd0, E_dst}, 32'd8);
            chk("mstall.valA", E_valA, 32'd100);
            chk("mstall.bubble", {31'd0, E_bubble}, 32'd0);
        end
        m_stall = 1'b0; M_dst = '0; W_dst = '0; e_valE = '0; M_valE = '0;
        #1 chk("hazard.D_stall", {31'd0, D_stall}, 32'd1);
        tick;
        chk("hazard.bubble", {31'd0, E_bubble}, 32'd1);
        chk("hazard.op", {26'd0, E_op}, 32'd0);

`ifdef E_FWD_EN
        // load now in M: its data comes from m_valM
        M_dst = 5'd8; M_isload = 1'b1; m_valM = 32'hDEAD_BEEF;
        #1 chk("lu.D_stall", {31'd0, D_stall}, 32'd0);
        tick;
        chk("lu.valA", E_valA, 32'hDEAD_BEEF);
        chk("lu.valB", E_valB, 32'd0);
        chk("lu.dst", {27'd0, E_dst}, 32'd9);
        M_dst = '0; M_isload = 1'b0; m_valM = '0;

        // E-stage forwarding
        set_d(1'b1, 6'h00, FADD, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0);
        tick;
        set_d(1'b1, 6'h00, FADD, 5'd3, 5'd3, 5'd4, 32'h0, 32'h0, 32'h0);
        e_valE = 32'h0000_0010;
        #1 chk("efwd.D_stall", {31'd0, D_stall}, 32'd0);
        tick;
        chk("efwd.valA", E_valA, 32'h10);
        chk("efwd.valB", E_valB, 32'h10);

        // priority E > M > W > register file
        set_d(1'b1, 6'h00, FADD, 5'd1, 5'd2, 5'd5, 32'h0, 32'h0, 32'h0);
        e_valE = '0;
        tick;
        set_d(1'b1, 6'h00, FADD, 5'd5, 5'd0, 5'd6, 32'hAA, 32'h0, 32'h0);
        e_valE = 32'd1; M_dst = 5'd5; M_valE = 32'd2; W_dst = 5'd5; W_val = 32'd3;
        tick;
        chk("prio.E", E_valA, 32'd1);
        tick;
        chk("prio.M", E_valA, 32'd2);
        M_dst = '0;
        tick;
        chk("prio.W", E_valA, 32'd3);
        W_dst = '0;
        tick;
        chk("prio.rf", E_valA, 32'hAA);

        // $0 is never forwarded
        set_d(1'b1, 6'h00, FADD, 5'd0, 5'd0, 5'd7, 32'h99, 32'h0, 32'h0);
        M_dst = '0; M_valE = 32'd7; W_val = 32'd9;
        tick;
        chk("zero.valA", E_valA, 32'd0);
`else
        // interlock: load in M, then W, then proceed with register-file value
        M_dst = 5'd8;
        #1 chk("ilk.M.D_stall", {31'd0, D_stall}, 32'd1);
        tick;
        chk("ilk.M.bubble", {31'd0, E_bubble}, 32'd1);
        M_dst = '0; W_dst = 5'd8;
        #1 chk("ilk.W.D_stall", {31'd0, D_stall}, 32'd1);
        tick;
        chk("ilk.W.bubble", {31'd0, E_bubble}, 32'd1);
        W_dst = '0;
        #1 chk("ilk.go.D_stall", {31'd0, D_stall}, 32'd0);
        tick;
        chk("ilk.go.valA", E_valA, 32'h55);
        chk("ilk.go.dst", {27'd0, E_dst}, 32'd9);

        // add $3 then add $4,$3,$3: three stall cycles (E, M, W)
        set_d(1'b1, 6'h00, FADD, 5'd1, 5'd2, 5'd3, 32'h1, 32'h2, 32'h0);
        tick;
        set_d(1'b1, 6'h00, FADD, 5'd3, 5'd3, 5'd4, 32'h77, 32'h77, 32'h0);
        #1 chk("add.E.D_stall", {31'd0, D_stall}, 32'd1);
        tick;
        chk("add.E.bubble", {31'd0, E_bubble}, 32'd1);
        M_dst = 5'd3;
        #1 chk("add.M.D_stall", {31'd0, D_stall}, 32'd1);
        tick;
        M_dst = '0; W_dst = 5'd3;
        #1 chk("add.W.D_stall", {31'd0, D_stall}, 32'd1);
        tick;
        W_dst = '0;
        #1 chk("add.go.D_stall", {31'd0, D_stall}, 32'd0);
        tick;
        chk("add.go.valA", E_valA, 32'h77);
        chk("add.go.valB", E_valB, 32'h77);

        // $0 source never interlocks; value passes straight through
        set_d(1'b1, 6'h00, FADD, 5'd0, 5'd0, 5'd7, 32'h99, 32'h0, 32'h0);
        M_valE = 32'd7;
        #1 chk("zero.D_stall", {31'd0, D_stall}, 32'd0);
        tick;
        chk("zero.valA", E_valA, 32'h99);
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
